key_entry: RTL
==============

KEY_ENTRY -- requirements
Module: key_entry

Interface
REQ-001 Parameter DIGITS, default 4: maximum BCD digits per operand.
REQ-002 clk  in  1  single clock; all logic on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 key_en  in  1  keypad "key held" level from the scanner, synchronous to clk, high for several cycles per press.
REQ-005 key_value  in  4  key code, stable while key_en high: 0-9 digit, 10 '+', 11 '-', 12 '*', 13 enter, 14 delete, 15 '/'.
REQ-006 cmd_valid  out  1  operand pair and operator available.
REQ-007 cmd_ready  in  1  downstream accepts the command when high together with cmd_valid.
REQ-008 cmd_op  out  2  operator: 00 '+', 01 '-', 10 '*', 11 '/'.
REQ-009 cmd_a, cmd_b  out  4*DIGITS each  operands, packed BCD, least-significant digit in [3:0].
REQ-010 disp_bcd  out  4*DIGITS  operand currently being entered (packed BCD).
REQ-011 disp_cnt  out  $clog2(DIGITS+1)  number of digits in disp_bcd.
REQ-012 disp_sel  out  1  0 = disp shows A, 1 = disp shows B.

Function
REQ-013 Key event = key_en sampled high while the registered previous key_en is low; exactly one event per press, regardless of hold length.
REQ-014 An event's effect SHALL appear on the outputs at the same clock edge where key_en is first sampled high (one-cycle latency from the key_en rise).
REQ-015 States: ENTER_A, ENTER_B, HOLD.
REQ-016 Digit in ENTER_A/ENTER_B with disp_cnt < DIGITS: entry <= {entry shifted left 4, digit}; disp_cnt+1.
REQ-017 Digit with disp_cnt == DIGITS is ignored; no state or output change.
REQ-018 Delete with disp_cnt > 0: entry shifted right 4 with zero fill; disp_cnt-1.
REQ-019 Delete in ENTER_B with disp_cnt == 0: return to ENTER_A, restore A's digits and count to disp, disp_sel=0.
REQ-020 Delete in ENTER_A with disp_cnt == 0 is ignored.
REQ-021 Operator in ENTER_A: latch A and operator, clear entry, go to ENTER_B, disp_sel=1; allowed even with disp_cnt == 0 (A = 0).
REQ-022 Operator in ENTER_B with disp_cnt == 0 replaces the latched operator; with disp_cnt > 0 it is ignored.
REQ-023 Enter in ENTER_B: latch B, assert cmd_valid, go to HOLD; enter in ENTER_A is ignored.
REQ-024 In HOLD, cmd_a/cmd_b/cmd_op and disp outputs are stable and all key events are dropped (not queued).
REQ-025 cmd_valid stays high until the cycle with cmd_valid && cmd_ready; on that edge: cmd_valid=0, A, B, entry and count cleared, state ENTER_A.
REQ-026 A key event in the same cycle as the accepting handshake is dropped.
REQ-027 cmd_a/cmd_b/cmd_op are don't-care while cmd_valid is low but SHALL hold their last latched values.

Reset
REQ-028 On rst_n low: state ENTER_A; cmd_valid=0; cmd_op=00; cmd_a, cmd_b, disp_bcd all 0; disp_cnt=0; disp_sel=0.
REQ-029 Previous-key_en register resets to 1, so a key held across reset release generates no event.
REQ-030 Reset asserted mid-entry or in HOLD aborts immediately; the pending command is lost.

Structure
REQ-031 Shared package key_pkg holds key-code constants (KEY_ADD=10 ... KEY_DIV=15), operator encodings, and the state enum.
REQ-032 Sub-module key_event_det (edge detector, REQ-013/029) is instantiated once; all remaining logic is in key_entry.

Verification
REQ-033 Reset, then keys 1,2,'+',3,enter with cmd_ready=0 -> cmd_valid=1, cmd_a=0x0012, cmd_op=00, cmd_b=0x0003; stable for 10 cycles; cmd_ready=1 for one cycle -> all cleared next edge.
REQ-034 Keys 9,8,7,6,5 -> disp_bcd=0x9876, disp_cnt=4; delete -> 0x0987, disp_cnt=3.
REQ-035 Keys 4,'*',delete -> disp_sel=0, disp_bcd=0x0004, disp_cnt=1; then '-','/',7,enter -> cmd_op=11, cmd_b=0x0007.
REQ-036 key_en held high 50 cycles with key_value=5 -> single digit entered (disp_cnt=1).
REQ-037 Key press during HOLD and on the handshake cycle -> no effect; after handshake disp_bcd=0, disp_cnt=0.
REQ-038 key_en high across rst_n release -> no event; rst_n pulsed low in ENTER_B -> all outputs per REQ-028 asynchronously.

Source files
------------

// File: rtl/key_pkg.sv
// Shared key codes, operator encodings and entry-state type for the keypad front end.
package key_pkg;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_ENT = 4'd13;
    localparam logic [3:0] KEY_DEL = 4'd14;
    localparam logic [3:0] KEY_DIV = 4'd15;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ENTER_A,
        ENTER_B,
        HOLD
    } state_t;

    function automatic logic is_op(input logic [3:0] key);
        return (key == KEY_ADD) || (key == KEY_SUB) || (key == KEY_MUL) || (key == KEY_DIV);
    endfunction

    function automatic logic [1:0] op_code(input logic [3:0] key);
        logic [1:0] op;
        op = OP_ADD;
        case (key)
            KEY_SUB: op = OP_SUB;
            KEY_MUL: op = OP_MUL;
            KEY_DIV: op = OP_DIV;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/key_entry_if.sv
// Command bus from the key entry block to the arithmetic unit (valid/ready handshake).
interface key_entry_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [4*DIGITS-1:0]   cmd_a;
    logic [4*DIGITS-1:0]   cmd_b;

    modport master (output cmd_valid, output cmd_op, output cmd_a, output cmd_b, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_a, input cmd_b, output cmd_ready);
endinterface

// File: rtl/key_event_det.sv
// Rising-edge detector on the scanner's key-held level; one event per press.
module key_event_det (
    input  logic clk,
    input  logic rst_n,
    input  logic key_en,
    output logic key_evt
);
    logic prev;

    // Resetting to 1 suppresses an event for a key already held at reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b1;
        else        prev <= key_en;
    end

    assign key_evt = key_en & ~prev;
endmodule

// File: rtl/key_entry.sv
// Keypad operand/operator entry: builds two BCD operands and an operator, then
// presents them as a command and holds until the downstream accepts.
module key_entry
    import key_pkg::*;
#(
    parameter  int unsigned DIGITS = 4,
    localparam int unsigned CW     = $clog2(DIGITS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_en,
    input  logic [3:0]          key_value,
    key_entry_if.master         cmd,
    output logic [4*DIGITS-1:0] disp_bcd,
    output logic [CW-1:0]       disp_cnt,
    output logic                disp_sel
);
    localparam logic [CW-1:0] MAX_CNT = CW'(DIGITS);

    logic                key_evt;
    logic                is_digit;
    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] entry_q, entry_d;
    logic [4*DIGITS-1:0] a_q, a_d;
    logic [4*DIGITS-1:0] b_q, b_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       acnt_q, acnt_d;
    logic [1:0]          op_q, op_d;
    logic                valid_q, valid_d;

    key_event_det u_det (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_en  (key_en),
        .key_evt (key_evt)
    );

    assign is_digit = (key_value <= 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENTER_A;
            entry_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            acnt_q  <= '0;
            op_q    <= OP_ADD;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            acnt_q  <= acnt_d;
            op_q    <= op_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        acnt_d  = acnt_q;
        op_d    = op_q;
        valid_d = valid_q;
        case (state_q)
            ENTER_A, ENTER_B: begin
                if (key_evt) begin
                    if (is_digit) begin
                        if (cnt_q < MAX_CNT) begin
                            entry_d = {entry_q[4*DIGITS-5:0], key_value};
                            cnt_d   = cnt_q + 1'b1;
                        end
                    end else if (key_value == KEY_DEL) begin
                        if (cnt_q != '0) begin
                            entry_d = {4'h0, entry_q[4*DIGITS-1:4]};
                            cnt_d   = cnt_q - 1'b1;
                        end else if (state_q == ENTER_B) begin
                            // Backing out of an empty B re-opens A for editing.
                            state_d = ENTER_A;
                            entry_d = a_q;
                            cnt_d   = acnt_q;
                        end
                    end else if (is_op(key_value)) begin
                        if (state_q == ENTER_A) begin
                            a_d     = entry_q;
                            acnt_d  = cnt_q;
                            op_d    = op_code(key_value);
                            entry_d = '0;
                            cnt_d   = '0;
                            state_d = ENTER_B;
                        end else if (cnt_q == '0) begin
                            op_d = op_code(key_value);
                        end
                    end else if ((key_value == KEY_ENT) && (state_q == ENTER_B)) begin
                        b_d     = entry_q;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (cmd.cmd_ready) begin
                    valid_d = 1'b0;
                    a_d     = '0;
                    acnt_d  = '0;
                    b_d     = '0;
                    entry_d = '0;
                    cnt_d   = '0;
                    state_d = ENTER_A;
                end
            end
            default: state_d = ENTER_A;
        endcase
    end

    assign cmd.cmd_valid = valid_q;
    assign cmd.cmd_op    = op_q;
    assign cmd.cmd_a     = a_q;
    assign cmd.cmd_b     = b_q;
    assign disp_bcd      = entry_q;
    assign disp_cnt      = cnt_q;
    assign disp_sel      = (state_q != ENTER_A);
endmodule
